// File: rtl/down_counter_pkg.sv
// Shared definitions for the down counter: controller state encoding and default width.
package down_counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/down_counter.sv
// Loadable down counter with terminal-count pulse and optional auto-reload.
// The controller has three states (IDLE/RUN/DONE). A load always overrides counting.
module down_counter
  import down_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] counter,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_counter;
  logic [WIDTH-1:0] w_counter_next;
  logic [WIDTH-1:0] r_reload;
  logic             r_tc;
  logic             w_run_step;
  logic             w_term;
  logic             w_load_zero;

  assign w_load_zero = (load_val == '0);
  assign w_run_step  = (r_state == RUN) && en && !load;
  assign w_term      = w_run_step && (r_counter == ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (load) begin
      w_state_next = w_load_zero ? IDLE : RUN;
    end else if (w_term && !auto_reload) begin
      w_state_next = DONE;
    end
  end

  always_comb begin
    busy = (r_state == RUN);
    done = (r_state == DONE);
  end

  // The != 0 guard keeps the count from ever wrapping to all-ones.
  always_comb begin
    w_counter_next = r_counter;
    if (load) begin
      w_counter_next = load_val;
    end else if (w_term) begin
      w_counter_next = auto_reload ? r_reload : '0;
    end else if (w_run_step && (r_counter != '0)) begin
      w_counter_next = r_counter - ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_counter <= '0;
      r_reload  <= '0;
      r_tc      <= 1'b0;
    end else begin
      r_counter <= w_counter_next;
      r_tc      <= w_term;
      if (load) begin
        r_reload <= load_val;
      end
    end
  end

  assign counter = r_counter;
  assign tc      = r_tc;

endmodule
